imem_loader: RTL and testbench

//  Write-side counterpart of the instruction memory: receives a program image as a byte

---
 rtl/imem_loader.sv | 153 +++++++++++++++
 tb/tb_imem_loader.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Byte-stream program loader: packs little-endian bytes into 32-bit words for the instruction memory.
// Optional trailing XOR checksum byte is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int IM_DEPTH = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        im_we,
  output logic [31:0] im_addr,
  output logic [31:0] im_wdata,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] word_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE, S_CSUM, S_DONE, S_ERROR
  } state_t;

  localparam logic [16:0] DEPTH = 17'(IM_DEPTH);

  state_t      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [1:0]  bcnt_q, bcnt_d;
  logic [31:0] word_q, word_d;
  logic [15:0] wcnt_q, wcnt_d;
  logic [15:0] len_new;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  csum_q, csum_d;
  localparam state_t S_AFTER_LAST = S_CSUM;
`else
  localparam state_t S_AFTER_LAST = S_DONE;
`endif

  assign len_new    = {rx_data, len_q[7:0]};
  assign word_count = wcnt_q;

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    bcnt_d   = bcnt_q;
    word_d   = word_q;
    wcnt_d   = wcnt_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d   = csum_q;
`endif
    rx_ready = 1'b0;
    im_we    = 1'b0;
    im_addr  = 32'd0;
    im_wdata = 32'd0;
    cpu_hold = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    error    = 1'b0;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        done     = (state_q == S_DONE);
        error    = (state_q == S_ERROR);
        cpu_hold = (state_q == S_ERROR);
        if (start) begin
          state_d = S_LEN_LO;
          wcnt_d  = 16'd0;
          bcnt_d  = 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d  = 8'd0;
`endif
        end
      end
      S_LEN_LO: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        cpu_hold = 1'b1;
        if (rx_valid) begin
          len_d[7:0] = rx_data;
          state_d    = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        cpu_hold = 1'b1;
        if (rx_valid) begin
          len_d = len_new;
          if (len_new == 16'd0)             state_d = S_AFTER_LAST;
          else if ({1'b0, len_new} > DEPTH) state_d = S_ERROR;
          else                              state_d = S_DATA;
        end
      end
      S_DATA: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        cpu_hold = 1'b1;
        if (rx_valid) begin
          // first byte of a word ends up in bits [7:0] after four shifts
          word_d = {rx_data, word_q[31:8]};
          bcnt_d = bcnt_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d = csum_q ^ rx_data;
`endif
          if (bcnt_q == 2'd3) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        busy     = 1'b1;
        cpu_hold = 1'b1;
        im_we    = 1'b1;
        im_addr  = {16'd0, wcnt_q};
        im_wdata = word_q;
        wcnt_d   = wcnt_q + 16'd1;
        state_d  = (wcnt_d == len_q) ? S_AFTER_LAST : S_DATA;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        cpu_hold = 1'b1;
        if (rx_valid) state_d = (rx_data == csum_q) ? S_DONE : S_ERROR;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      len_q   <= 16'd0;
      bcnt_q  <= 2'd0;
      word_q  <= 32'd0;
      wcnt_q  <= 16'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q  <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      bcnt_q  <= bcnt_d;
      word_q  <= word_d;
      wcnt_q  <= wcnt_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed and randomized images against a word-list model.
module tb_imem_loader;

  logic        clk, rst, start, rx_valid, rx_ready;
  logic [7:0]  rx_data;
  logic        im_we, cpu_hold, busy, done, error;
  logic [31:0] im_addr, im_wdata;
  logic [15:0] word_count;

  int checks = 0;
  int errors = 0;
  int ready_viol = 0;
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  logic [31:0] exp_words[$];

  imem_loader #(.IM_DEPTH(1024)) dut (
    .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error), .word_count(word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // write port observer: one entry per im_we pulse
  always @(negedge clk) begin
    if (im_we) begin
      wr_addr.push_back(im_addr);
      wr_data.push_back(im_wdata);
      if (rx_ready) ready_viol++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    rx_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit rnd);
    bit sent = 0;
    int guard = 0;
    while (!sent && guard < 200) begin
      @(negedge clk);
      rx_data  = b;
      rx_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (rx_valid && rx_ready) sent = 1;
      guard++;
    end
    if (!sent) chk("send_timeout", 32'(sent), 32'd1);
  endtask

  task automatic idle_rx();
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_end();
    int k = 0;
    while (!(done || error) && k < 100) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("end_timeout", 32'(done || error), 32'd1);
  endtask

  task automatic compare_writes(input string tag);
    chk({tag, "_nwrites"}, 32'(wr_addr.size()), 32'(exp_words.size()));
    for (int i = 0; i < exp_words.size() && i < wr_addr.size(); i++) begin
      chk({tag, "_addr"}, wr_addr[i], 32'(i));
      chk({tag, "_data"}, wr_data[i], exp_words[i]);
    end
  endtask

  // full session driven from the expected word list; poke>=0 pulses start before that data byte
  task automatic run_session(input string tag, input bit rnd, input int poke);
    int n;
    logic [7:0] b, cs;
    wr_addr.delete();
    wr_data.delete();
    n = exp_words.size();
    cs = 8'h00;
    pulse_start();
    chk({tag, "_busy0"}, 32'(busy), 32'd1);
    chk({tag, "_hold0"}, 32'(cpu_hold), 32'd1);
    chk({tag, "_done0"}, 32'(done), 32'd0);
    chk({tag, "_wc0"}, 32'(word_count), 32'd0);
    send_byte(n[7:0], rnd);
    send_byte(n[15:8], rnd);
    for (int w = 0; w < n; w++) begin
      for (int k = 0; k < 4; k++) begin
        b = exp_words[w][8*k +: 8];
        if (poke == 4*w + k) begin
          pulse_start();
          chk({tag, "_busy_poke"}, 32'(busy), 32'd1);
        end
        send_byte(b, rnd);
        cs = cs ^ b;
      end
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(cs, rnd);
`endif
    idle_rx();
    wait_end();
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_error"}, 32'(error), 32'd0);
    chk({tag, "_hold"}, 32'(cpu_hold), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_wc"}, 32'(word_count), 32'(n));
    compare_writes(tag);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_we", 32'(im_we), 32'd0);
    chk("rst_ready", 32'(rx_ready), 32'd0);
    chk("rst_hold", 32'(cpu_hold), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_wc", 32'(word_count), 32'd0);
    rst = 1'b0;

    // IDLE ignores offered bytes
    @(negedge clk);
    rx_valid = 1'b1; rx_data = 8'h55;
    repeat (3) @(negedge clk);
    #1;
    chk("idle_ready", 32'(rx_ready), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    rx_valid = 1'b0;

    exp_words = '{32'h12345678, 32'hDEADBEEF};
    run_session("basic", 1'b0, -1);
    repeat (3) @(negedge clk);
    #1;
    chk("done_persist", 32'(done), 32'd1);

    run_session("rndvalid", 1'b1, -1);
    run_session("poke", 1'b1, 2);

    for (int it = 0; it < 4; it++) begin
      int n = $urandom_range(1, 6);
      exp_words.delete();
      for (int i = 0; i < n; i++) exp_words.push_back($urandom);
      run_session("random", 1'b1, -1);
    end

    exp_words.delete();
    run_session("zero_len", 1'b0, -1);

    // length 0x0401 exceeds the 1024-word memory
    wr_addr.delete(); wr_data.delete();
    pulse_start();
    send_byte(8'h01, 1'b0);
    send_byte(8'h04, 1'b0);
    idle_rx();
    wait_end();
    chk("len_err_error", 32'(error), 32'd1);
    chk("len_err_done", 32'(done), 32'd0);
    chk("len_err_hold", 32'(cpu_hold), 32'd1);
    chk("len_err_busy", 32'(busy), 32'd0);
    repeat (5) @(negedge clk);
    #1;
    chk("len_err_persist", 32'(error), 32'd1);
    chk("len_err_nwrites", 32'(wr_addr.size()), 32'd0);

    // restart from ERROR
    exp_words = '{32'hA5A5_0F0F};
    run_session("after_err", 1'b0, -1);

    // reset after six data bytes: word 0 written once, word 1 never
    wr_addr.delete(); wr_data.delete();
    pulse_start();
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b0);
    send_byte(8'h55, 1'b0);
    send_byte(8'h66, 1'b0);
    @(negedge clk);
    rx_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("midrst_we", 32'(im_we), 32'd0);
    chk("midrst_hold", 32'(cpu_hold), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_ready", 32'(rx_ready), 32'd0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("midrst_nwrites", 32'(wr_addr.size()), 32'd1);
    if (wr_addr.size() > 0) begin
      chk("midrst_addr", wr_addr[0], 32'd0);
      chk("midrst_data", wr_data[0], 32'h44332211);
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    exp_words = '{32'h08040201};
    run_session("csum_ok", 1'b0, -1);
    wr_addr.delete(); wr_data.delete();
    pulse_start();
    send_byte(8'h01, 1'b0); send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0); send_byte(8'h02, 1'b0);
    send_byte(8'h04, 1'b0); send_byte(8'h08, 1'b0);
    send_byte(8'h0E, 1'b0);
    idle_rx();
    wait_end();
    chk("csum_bad_error", 32'(error), 32'd1);
    chk("csum_bad_done", 32'(done), 32'd0);
    chk("csum_bad_hold", 32'(cpu_hold), 32'd1);
    compare_writes("csum_bad");
`endif

    chk("ready_in_write", 32'(ready_viol), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
